// File: rtl/tournament_predictor_gs_pkg.sv
// Shared defaults and helpers for the tournament branch predictor.
// The ROB entry fields size from the PRED_* defaults below.
package tournament_predictor_gs_pkg;

   localparam int PRED_IDX_BITS  = 8;
   localparam int PRED_HIST_BITS = 8;
   localparam int PRED_CTR_BITS  = 2;
   localparam int PRED_SEL_BITS  = 2;
   localparam int PRED_PC_LSB    = 2;
   localparam int PRED_GSHARE    = 1;

   // Widest counter any table may use; narrower counters are zero-extended into it.
   localparam int CTR_MAX_BITS = 4;

   typedef enum logic {
      SEL_LOCAL  = 1'b0,
      SEL_GLOBAL = 1'b1
   } sel_src_e;

   // One saturating step of an up/down counter bounded by [0, max_val].
   function automatic logic [CTR_MAX_BITS-1:0] sat_step(
      input logic [CTR_MAX_BITS-1:0] val,
      input logic                    up,
      input logic [CTR_MAX_BITS-1:0] max_val
   );
      if (up)
         return (val == max_val) ? val : val + 1'b1;
      else
         return (val == '0) ? val : val - 1'b1;
   endfunction

endpackage

// File: rtl/tournament_predictor_gs_ctr_table.sv
// Table of saturating counters: one combinational read port, one inc/dec write port.
// Used for the global, local and selector tables of the tournament predictor.
module pred_ctr_table
   import tournament_predictor_gs_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WIDTH = 2,
   parameter int INIT  = 1
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [WIDTH-1:0]         rd_val,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_idx,
   input  logic                     wr_up
);

   localparam logic [WIDTH-1:0]        INIT_VAL = WIDTH'(INIT);
   localparam logic [CTR_MAX_BITS-1:0] MAX_VAL  = CTR_MAX_BITS'((1 << WIDTH) - 1);

   logic [WIDTH-1:0] mem [DEPTH];

   // Reads see the value before any same-cycle write.
   assign rd_val = mem[rd_idx];

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         // NOTE: every entry is a flop with a defined reset value, so this stays a
         // register file rather than a RAM macro; the reset loop unrolls at elaboration.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= INIT_VAL;
         end
      end else if (wr_en) begin
         // NOTE: non-blocking so the read port sees the old value for the whole cycle.
         mem[wr_idx] <= WIDTH'(sat_step(CTR_MAX_BITS'(mem[wr_idx]), wr_up, MAX_VAL));
      end
   end

endmodule

// File: rtl/tournament_predictor_gs.sv
// Tournament branch predictor: gshare global + PC-indexed local + per-PC selector,
// with speculative history, commit-time training and misprediction repair.
module tournament_predictor_gs
   import tournament_predictor_gs_pkg::*;
#(
   parameter int IDX_BITS  = PRED_IDX_BITS,
   parameter int HIST_BITS = PRED_HIST_BITS,
   parameter int CTR_BITS  = PRED_CTR_BITS,
   parameter int SEL_BITS  = PRED_SEL_BITS,
   parameter int PC_LSB    = PRED_PC_LSB,
   parameter int GSHARE    = PRED_GSHARE
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                rdy_in,
   input  logic                inst_req,
   input  logic [31:0]         inst_addr,
   output logic                pred_out,
   output logic [IDX_BITS-1:0] g_ind_out,
   output logic [IDX_BITS-1:0] l_ind_out,
   output logic                g_pred_out,
   output logic                l_pred_out,
   input  logic                br_req,
   input  logic                br_taken,
   input  logic                br_correct,
   input  logic [IDX_BITS-1:0] br_g_ind,
   input  logic [IDX_BITS-1:0] br_l_ind,
   input  logic                br_g_pred,
   input  logic                br_l_pred,
   output logic [31:0]         stat_pred_cnt,
   output logic [31:0]         stat_miss_cnt
);

   localparam int DEPTH    = 1 << IDX_BITS;
   localparam int CTR_INIT = (1 << (CTR_BITS - 1)) - 1;
   localparam int SEL_INIT = (1 << (SEL_BITS - 1)) - 1;

   logic [HIST_BITS-1:0] spec_hist;
   logic [HIST_BITS-1:0] arch_hist;
   logic [IDX_BITS-1:0]  pc_idx;
   logic [IDX_BITS-1:0]  g_idx;
   logic [CTR_BITS-1:0]  g_ctr;
   logic [CTR_BITS-1:0]  l_ctr;
   logic [SEL_BITS-1:0]  sel_ctr;
   sel_src_e             sel_src;
   logic                 commit_en;
   logic                 sel_wr_en;
   logic                 sel_wr_up;
   logic                 unused_addr_bits;

   // Only a window of the PC feeds the index; the remaining bits are intentionally ignored.
   assign unused_addr_bits = ^inst_addr;

   // A stalled pipeline must not train tables; reset still applies inside the tables.
   assign commit_en = rdy_in & br_req;

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      pc_idx  = inst_addr[PC_LSB +: IDX_BITS];
      g_idx   = IDX_BITS'(spec_hist);
      if (GSHARE != 0) begin
         g_idx = g_idx ^ pc_idx;
      end
      sel_src    = sel_src_e'(sel_ctr[SEL_BITS-1]);
      g_pred_out = g_ctr[CTR_BITS-1];
      l_pred_out = l_ctr[CTR_BITS-1];
      pred_out   = (sel_src == SEL_GLOBAL) ? g_pred_out : l_pred_out;
      g_ind_out  = g_idx;
      l_ind_out  = pc_idx;
   end

   // Selector only learns when the two components disagreed on this branch.
   assign sel_wr_en = commit_en & (br_g_pred != br_l_pred);
   assign sel_wr_up = (br_g_pred == br_taken);

   pred_ctr_table #(
      .DEPTH (DEPTH),
      .WIDTH (CTR_BITS),
      .INIT  (CTR_INIT)
   ) u_g_tab (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rd_idx   (g_idx),
      .rd_val   (g_ctr),
      .wr_en    (commit_en),
      .wr_idx   (br_g_ind),
      .wr_up    (br_taken)
   );

   pred_ctr_table #(
      .DEPTH (DEPTH),
      .WIDTH (CTR_BITS),
      .INIT  (CTR_INIT)
   ) u_l_tab (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rd_idx   (pc_idx),
      .rd_val   (l_ctr),
      .wr_en    (commit_en),
      .wr_idx   (br_l_ind),
      .wr_up    (br_taken)
   );

   pred_ctr_table #(
      .DEPTH (DEPTH),
      .WIDTH (SEL_BITS),
      .INIT  (SEL_INIT)
   ) u_sel_tab (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .rd_idx   (pc_idx),
      .rd_val   (sel_ctr),
      .wr_en    (sel_wr_en),
      .wr_idx   (br_l_ind),
      .wr_up    (sel_wr_up)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         spec_hist <= '0;
         arch_hist <= '0;
      end else if (rdy_in) begin
         if (br_req) begin
            arch_hist <= HIST_BITS'({arch_hist, br_taken});
         end
         // The ROB flush on a mispredict kills the fetch path, so repair beats the shift.
         if (br_req && !br_correct) begin
            spec_hist <= HIST_BITS'({arch_hist, br_taken});
         end else if (inst_req) begin
            spec_hist <= HIST_BITS'({spec_hist, pred_out});
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         stat_pred_cnt <= '0;
         stat_miss_cnt <= '0;
      end else if (commit_en) begin
         stat_pred_cnt <= stat_pred_cnt + 32'd1;
         if (!br_correct) begin
            stat_miss_cnt <= stat_miss_cnt + 32'd1;
         end
      end
   end

endmodule
